// File: rtl/axis_sa_out_transpose_if.sv
// rtl/axis_sa_out_transpose_if.sv - valid/ready/data/last stream bundle for the output transpose stage
interface axis_sa_out_transpose_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_sa_out_transpose.sv
// rtl/axis_sa_out_transpose.sv - column-beat to row-beat matrix reorder buffer
// AXIS_SA_OUT_DBUF_EN selects ping-pong banks; otherwise one bank with a FILL/DRAIN FSM.
module axis_sa_out_transpose #(
    parameter int R  = 8,
    parameter int C  = 4,
    parameter int WY = 15
) (
    input  logic clk,
    input  logic rst,
    axis_sa_out_transpose_if.slave  s,
    axis_sa_out_transpose_if.master m,
    output logic err
);
    localparam int WCW = (C > 1) ? $clog2(C) : 1;
    localparam int RCW = (R > 1) ? $clog2(R) : 1;
`ifdef AXIS_SA_OUT_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [WY-1:0]   bank [NB][R][C];
    logic [WCW-1:0]  wc;
    logic [RCW-1:0]  rc;
    logic [WCW-1:0]  wcol;
    logic            s_fire;
    logic            m_fire;
    logic            wc_end;
    logic            close;
    logic            release_b;
    logic [C*WY-1:0] m_word;

    assign s_fire    = s.valid && s.ready;
    assign m_fire    = m.valid && m.ready;
    assign wc_end    = (wc == WCW'(C - 1));
    assign close     = s_fire && (wc_end || s.last);
    assign release_b = m_fire && (rc == RCW'(R - 1));
    // Input beat i carries column C-1-i, so the array's reverse order lands in natural slots.
    assign wcol      = WCW'(C - 1) - wc;

`ifdef AXIS_SA_OUT_DBUF_EN
    logic          wb;
    logic          rb;
    logic          up;
    logic [NB-1:0] full;

    assign s.ready = up && !full[wb];
    assign m.valid = full[rb];

    always_ff @(posedge clk) begin
        if (rst) begin
            wb   <= 1'b0;
            rb   <= 1'b0;
            up   <= 1'b0;
            full <= '0;
        end else begin
            up <= 1'b1;
            if (close) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (release_b) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end
`else
    localparam logic wb = 1'b0;
    localparam logic rb = 1'b0;

    typedef enum logic {FILL, DRAIN} state_t;
    state_t state;
    logic   ready_q;
    logic   valid_q;

    assign s.ready = ready_q;
    assign m.valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (close) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (release_b) begin
                        state   <= FILL;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
`endif

    // Released banks are zeroed so an early-closed matrix reads 0 in its unwritten columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc  <= '0;
            rc  <= '0;
            err <= 1'b0;
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        bank[b][r][c] <= '0;
        end else begin
            if (s_fire) begin
                for (int r = 0; r < R; r++)
                    bank[wb][r][wcol] <= s.data[r*WY +: WY];
                wc <= close ? '0 : wc + 1'b1;
                if (s.last != wc_end)
                    err <= 1'b1;
            end
            if (m_fire)
                rc <= release_b ? '0 : rc + 1'b1;
            if (release_b) begin
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        bank[rb][r][c] <= '0;
            end
        end
    end

    always_comb begin
        m_word = '0;
        for (int c = 0; c < C; c++)
            m_word[c*WY +: WY] = bank[rb][rc][c];
    end

    assign m.data = m_word;
    assign m.last = (rc == RCW'(R - 1));
endmodule

// File: tb/tb_axis_sa_out_transpose.sv
// tb/tb_axis_sa_out_transpose.sv - randomized self-checking bench for axis_sa_out_transpose
module tb_axis_sa_out_transpose;
    localparam int R  = 8;
    localparam int C  = 4;
    localparam int WY = 15;
`ifdef AXIS_SA_OUT_DBUF_EN
    localparam int EXP_B_STALLS = 0;
`else
    localparam int EXP_B_STALLS = R;
`endif

    logic clk = 1'b0;
    logic rst;
    logic err;

    axis_sa_out_transpose_if #(.W(R*WY)) s_if ();
    axis_sa_out_transpose_if #(.W(C*WY)) m_if ();

    axis_sa_out_transpose #(.R(R), .C(C), .WY(WY)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s_if),
        .m   (m_if),
        .err (err)
    );

    initial forever #5 clk = ~clk;

    logic [WY-1:0]   ym [R][C];
    logic [C*WY-1:0] exp_d[$];
    logic [C*WY-1:0] got_d[$];
    logic            exp_l[$];
    logic            got_l[$];
    int              vectors = 0;
    int              miscompares = 0;
    bit              rnd_rdy = 1'b0;
    int              stab_n = 0;
    int              stab_bad = 0;
    bit              prev_stall = 1'b0;
    logic [C*WY-1:0] prev_d;
    logic            prev_l;

    // Random downstream backpressure, applied just after each active edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) m_if.ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: records handshakes and what a stalled beat looks like one cycle later.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (m_if.valid && m_if.ready) begin
                got_d.push_back(m_if.data);
                got_l.push_back(m_if.last);
            end
            if (prev_stall) begin
                stab_n++;
                if (!m_if.valid || m_if.data !== prev_d || m_if.last !== prev_l) stab_bad++;
            end
            prev_stall = m_if.valid && !m_if.ready;
            prev_d     = m_if.data;
            prev_l     = m_if.last;
        end
    end

    task automatic fill_random();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                ym[r][c] = WY'($urandom);
    endtask

    // Expected rows: columns C-1 down to C-ncols were written, anything else reads 0.
    task automatic model_push(input int ncols);
        logic [C*WY-1:0] row;
        for (int r = 0; r < R; r++) begin
            row = '0;
            for (int c = 0; c < C; c++)
                if (c >= C - ncols) row[c*WY +: WY] = ym[r][c];
            exp_d.push_back(row);
            exp_l.push_back(r == R - 1);
        end
    endtask

    task automatic send_beat(input int i, input bit lst, output int stalls);
        logic [R*WY-1:0] d;
        bit done;
        for (int r = 0; r < R; r++) d[r*WY +: WY] = ym[r][C-1-i];
        s_if.data  = d;
        s_if.last  = lst;
        s_if.valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (s_if.ready) done = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: s_ready stayed %0b, required 1", s_if.ready);
        end
    endtask

    task automatic send_matrix(input int ncols, input bit keep, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < ncols; i++) begin
            send_beat(i, (i == ncols - 1), st);
            stalls += st;
        end
        if (!keep) s_if.valid = 1'b0;
    endtask

    task automatic wait_rows();
        int n;
        for (int t = 0; t < 4000 && got_d.size() < exp_d.size(); t++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (got_d.size() !== exp_d.size()) begin
            miscompares++;
            $display("FAIL row_count: got %0d rows, required %0d", got_d.size(), exp_d.size());
        end
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL row%0d: got data=%h last=%0b, required data=%h last=%0b",
                         i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (s_if.ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %0b required 0", s_if.ready); end
        vectors++;
        if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %0b required 0", m_if.valid); end
        vectors++;
        if (m_if.last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last: got %0b required 0", m_if.last); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b required 0", err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (s_if.ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_s_ready: got %0b required 1", s_if.ready); end
    endtask

    task automatic test_basic();
        int st;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                ym[r][c] = WY'(16 * r + c);
        model_push(C);
        for (int i = 0; i < C - 1; i++) send_beat(i, 1'b0, st);
        vectors++;
        if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_before_close: got %0b required 0", m_if.valid); end
        send_beat(C - 1, 1'b1, st);
        s_if.valid = 1'b0;
        vectors++;
        if (m_if.valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: m_valid got %0b required 1", m_if.valid); end
        wait_rows();
    endtask

    task automatic test_back_to_back();
        int st;
        int st_b;
        m_if.ready = 1'b1;
        fill_random();
        model_push(C);
        send_matrix(C, 1'b1, st);
        vectors++;
        if (m_if.valid !== 1'b1) begin miscompares++; $display("FAIL b2b_a_valid: got %0b required 1", m_if.valid); end
        fill_random();
        model_push(C);
        send_matrix(C, 1'b0, st_b);
        vectors++;
        if (st_b !== EXP_B_STALLS) begin miscompares++; $display("FAIL b2b_stalls: got %0d required %0d", st_b, EXP_B_STALLS); end
        wait_rows();
    endtask

    task automatic test_backpressure();
        int st;
        stab_n = 0;
        stab_bad = 0;
        rnd_rdy = 1'b1;
        for (int k = 0; k < 50; k++) begin
            fill_random();
            model_push(C);
            send_matrix(C, 1'b0, st);
        end
        wait_rows();
        rnd_rdy = 1'b0;
        m_if.ready = 1'b1;
        vectors++;
        if (stab_bad !== 0) begin miscompares++; $display("FAIL stall_stability: %0d unstable of %0d stalled cycles, required 0", stab_bad, stab_n); end
        vectors++;
        if (stab_n == 0) begin miscompares++; $display("FAIL stall_coverage: got %0d stalled cycles, required >0", stab_n); end
    endtask

    task automatic test_neg_extremes();
        int st;
        m_if.ready = 1'b1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                ym[r][c] = 15'h4000;
        model_push(C);
        send_matrix(C, 1'b0, st);
        wait_rows();
    endtask

    task automatic test_early_last();
        int st;
        m_if.ready = 1'b1;
        fill_random();
        model_push(2);
        send_matrix(2, 1'b0, st);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL early_err: got %0b required 1", err); end
        wait_rows();
        fill_random();
        model_push(C);
        send_matrix(C, 1'b0, st);
        wait_rows();
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %0b required 1", err); end
    endtask

    task automatic test_reset_mid();
        int st;
        m_if.ready = 1'b0;
        fill_random();
        model_push(C);
        send_matrix(C, 1'b0, st);
        m_if.ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_if.ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL midrst_m_valid: got %0b required 0", m_if.valid); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %0b required 0", err); end
        vectors++;
        if (got_d.size() !== 2) begin
            miscompares++;
            $display("FAIL midrst_rows_before: got %0d rows required 2", got_d.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (got_d[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL midrst_row%0d: got %h required %h", i, got_d[i], exp_d[i]);
                end
            end
        end
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_if.ready = 1'b1;
        fill_random();
        model_push(C);
        send_matrix(C, 1'b0, st);
        wait_rows();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_neg_extremes();
        test_early_last();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
